// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: divider FSM states and constants.
package mips_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned DIV_CNT_W = 6;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage : mips_pkg

// File: rtl/divide_unit_if.sv
// Divider command/result bundle between the control unit (master) and divide_unit (slave).
//   Start/Signed/A/B : launch pulse, signedness and operands from the control unit
//   Hi/Lo            : remainder / quotient
//   Busy/EndDivFlag  : activity level and one-cycle completion pulse
//   DivZero          : divisor was zero on the last accepted operation
interface divide_unit_if;
    import mips_pkg::*;

    logic                 Start;
    logic                 Signed;
    logic [DIV_WIDTH-1:0] A;
    logic [DIV_WIDTH-1:0] B;
    logic [DIV_WIDTH-1:0] Hi;
    logic [DIV_WIDTH-1:0] Lo;
    logic                 Busy;
    logic                 EndDivFlag;
    logic                 DivZero;

    modport master (
        output Start, Signed, A, B,
        input  Hi, Lo, Busy, EndDivFlag, DivZero
    );

    modport slave (
        input  Start, Signed, A, B,
        output Hi, Lo, Busy, EndDivFlag, DivZero
    );

endinterface : divide_unit_if

// File: rtl/divide_unit_div_step.sv
// One combinational restoring-division iteration.
//   rem/dividend_msb/divisor : current partial remainder, next dividend bit, divisor magnitude
//   rem_next/quot_bit        : updated partial remainder and the quotient bit produced
module div_step
    import mips_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem,
    input  logic                 dividend_msb,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_next,
    output logic                 quot_bit
);

    logic [DIV_WIDTH:0] shifted;
    logic [DIV_WIDTH:0] trial;

    // rem < divisor always holds, so a 33-bit trial's MSB is a reliable sign bit.
    always_comb begin
        shifted  = {rem, dividend_msb};
        trial    = shifted - {1'b0, divisor};
        quot_bit = ~trial[DIV_WIDTH];
        rem_next = trial[DIV_WIDTH] ? shifted[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
    end

endmodule : div_step

// File: rtl/divide_unit.sv
// Sequential 32-bit DIV/DIVU unit: restoring division on magnitudes, one quotient
// bit per clock, then a sign fix-up. Quotient -> Lo, remainder -> Hi.
//   Clk, Reset : clock and synchronous active-high reset
//   bus        : divide_unit_if.slave (Start/Signed/A/B in, Hi/Lo/Busy/EndDivFlag/DivZero out)
module divide_unit
    import mips_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    divide_unit_if.slave  bus
);

    div_state_t           state_q, state_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] dvd_q, dvd_d;   // dividend, shifts the quotient in from the LSB
    logic [DIV_WIDTH-1:0] dsr_q, dsr_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] hi_q, hi_d;
    logic [DIV_WIDTH-1:0] lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 flag_q, flag_d;
    logic                 dz_q, dz_d;

    logic [DIV_WIDTH-1:0] step_rem;
    logic                 step_qbit;

    div_step u_step (
        .rem          (rem_q),
        .dividend_msb (dvd_q[DIV_WIDTH-1]),
        .divisor      (dsr_q),
        .rem_next     (step_rem),
        .quot_bit     (step_qbit)
    );

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            flag_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            flag_q   <= flag_d;
            dz_q     <= dz_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        flag_d   = 1'b0;
        dz_d     = dz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.B == '0) begin
                        hi_d    = bus.A;
                        lo_d    = DIV_ZERO_QUOT;
                        dz_d    = 1'b1;
                        flag_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        sign_a_d = bus.Signed & bus.A[DIV_WIDTH-1];
                        sign_b_d = bus.Signed & bus.B[DIV_WIDTH-1];
                        // 0x80000000 negates to itself, which is the correct 2^31 magnitude.
                        dvd_d    = sign_a_d ? -bus.A : bus.A;
                        dsr_d    = sign_b_d ? -bus.B : bus.B;
                        rem_d    = '0;
                        cnt_d    = '0;
                        dz_d     = 1'b0;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[DIV_WIDTH-2:0], step_qbit};
                cnt_d = cnt_q + DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = (sign_a_q ^ sign_b_q) ? -dvd_q : dvd_q;
                hi_d    = sign_a_q ? -rem_q : rem_q;
                flag_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.Hi         = hi_q;
    assign bus.Lo         = lo_q;
    assign bus.Busy       = busy_q;
    assign bus.EndDivFlag = flag_q;
    assign bus.DivZero    = dz_q;

endmodule : divide_unit

// File: tb/tb_divide_unit.sv
// Self-checking bench for divide_unit: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_divide_unit;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    divide_unit_if bus ();

    divide_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // MIPS DIV/DIVU semantics: truncating division, remainder takes the dividend's sign.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFFFFFF;
            dz = 1'b1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'({32'd0, a});
            sb = s ? longint'($signed(b)) : longint'({32'd0, b});
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
            dz = 1'b0;
        end
    endtask

    // Launch at the current negedge (cycle n) and follow the operation cycle by cycle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                           input bit repulse, input string tag);
        logic [31:0] eh, el;
        logic        ed;
        int          lat, flag_at, flags;
        bit          busy_ok;
        model(a, b, s, eh, el, ed);
        lat        = (b == 32'd0) ? 1 : 34;
        bus.Start  = 1'b1;
        bus.A      = a;
        bus.B      = b;
        bus.Signed = s;
        @(negedge Clk);
        bus.Start  = 1'b0;
        bus.A      = $urandom;
        bus.B      = $urandom;
        bus.Signed = ~s;
        flag_at    = -1;
        flags      = 0;
        busy_ok    = 1'b1;
        for (int k = 1; k <= lat + 1; k++) begin
            if (bus.EndDivFlag === 1'b1) begin
                flags++;
                flag_at = k;
                check({tag, "_lo"}, bus.Lo, el);
                check({tag, "_hi"}, bus.Hi, eh);
                check({tag, "_dz"}, {31'd0, bus.DivZero}, {31'd0, ed});
            end
            if (bus.Busy !== ((k <= lat) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
            if (repulse && k == 5) begin
                bus.Start  = 1'b1;
                bus.A      = 32'd1000;
                bus.B      = 32'd3;
                bus.Signed = 1'b0;
            end else begin
                bus.Start = 1'b0;
            end
            if (k == lat + 1) begin
                check({tag, "_hold_lo"}, bus.Lo, el);
                check({tag, "_hold_hi"}, bus.Hi, eh);
                check({tag, "_hold_dz"}, {31'd0, bus.DivZero}, {31'd0, ed});
            end
            @(negedge Clk);
        end
        check({tag, "_flag_cycle"}, 32'(flag_at), 32'(lat));
        check({tag, "_flag_count"}, 32'(flags), 32'd1);
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_hi"},   bus.Hi, 32'd0);
        check({tag, "_lo"},   bus.Lo, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
        check({tag, "_flag"}, {31'd0, bus.EndDivFlag}, 32'd0);
        check({tag, "_dz"},   {31'd0, bus.DivZero}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs;

        Reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check_cleared("reset");
        @(negedge Clk);

        run_div(32'd100,        32'd7,          1'b0, 1'b0, "u100_7");
        run_div(32'hFFFFFFF9,   32'd2,          1'b1, 1'b0, "s_m7_2");
        run_div(32'hFFFFFFF9,   32'd2,          1'b0, 1'b0, "u_m7_2");
        run_div(32'h12345678,   32'd0,          1'b0, 1'b0, "dz_u");
        run_div(32'h12345678,   32'd0,          1'b1, 1'b0, "dz_s");
        run_div(32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b0, "s_ovf");
        run_div(32'd7,          32'hFFFFFFFE,   1'b1, 1'b0, "s_7_m2");
        run_div(32'd12345,      32'd1,          1'b0, 1'b0, "u_div1");
        run_div(32'd5,          32'hFFFFFFFF,   1'b0, 1'b0, "u_small_big");
        run_div(32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 1'b0, "u_max_max");
        run_div(32'h0BADF00D,   32'h00001234,   1'b0, 1'b1, "repulse");

        // Reset in mid-operation: launch in cycle n, assert Reset in cycle n+10.
        bus.Start  = 1'b1;
        bus.A      = 32'd100;
        bus.B      = 32'd7;
        bus.Signed = 1'b0;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_cleared("midreset");
        @(negedge Clk);
        check_cleared("midreset_settled");
        run_div(32'd9, 32'd3, 1'b0, 1'b0, "after_reset");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                3:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_div(ra, rb, rs, 1'b0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_divide_unit

// File: doc/divide_unit.md
# divide_unit

Sequential 32-bit integer divider for the MIPS datapath, serving DIV and DIVU: the inverse companion of the shift-add multiplier. It computes one quotient bit per clock with restoring division on magnitudes, then applies a sign fix-up. It writes the quotient to LO and the remainder to HI. The control unit launches it with a one-cycle start pulse and waits in a stall state until the completion flag rises.

## Interface
- WIDTH, 32, operand width; all behaviour below is specified for 32.
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle launch pulse from the control unit; honoured only in IDLE.
- Signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with Start.
- A  input  WIDTH  dividend; sampled with Start.
- B  input  WIDTH  divisor; sampled with Start.
- Hi  output  WIDTH  remainder, registered.
- Lo  output  WIDTH  quotient, registered.
- Busy  output  1  high in every state except IDLE.
- EndDivFlag  output  1  one-cycle pulse; Hi/Lo are valid in this cycle.
- DivZero  output  1  set with EndDivFlag when B was 0; holds until the next accepted Start.

## Operation
- States:
  - IDLE: waiting for Start.
  - CALC: runs 32 iterations.
  - FIX: applies sign correction.
  - DONE: asserts EndDivFlag.
- IDLE, Start=1, B!=0:
  - Latch the signs of A and B when Signed=1; otherwise both signs are 0.
  - Load the dividend register with |A|, the divisor register with |B| and the partial remainder with 0.
  - Clear the 6-bit counter and DivZero, then go to CALC.
- IDLE, Start=1, B==0:
  - Go to DONE with Hi=A, Lo=32'hFFFFFFFF and DivZero=1.
  - Signed is irrelevant in this case.
- CALC, each cycle:
  - Form a 33-bit trial value, {rem, dividend MSB} minus divisor.
  - If the trial value is non-negative, keep it as rem and shift 1 into the quotient; otherwise keep the shifted rem and shift in 0.
  - Shift the dividend left by 1 and increment the counter.
  - After the 32nd iteration (counter==31 at that edge), go to FIX.
- FIX:
  - Lo = quotient, negated if the latched signs differ.
  - Hi = rem, negated if the dividend sign is 1, so the remainder takes the dividend's sign (MIPS semantics).
  - Go to DONE.
- DONE: EndDivFlag=1, then return to IDLE. Hi and Lo hold their values until the next accepted Start loads new results.
- Start in any state other than IDLE is ignored, with no effect on the current operation.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000 and Hi=0, because the magnitude 2^31 wraps. This case is not flagged.
- Reset, including in mid-operation: state returns to IDLE, and Hi, Lo, Busy, EndDivFlag, DivZero and the counter all go to 0. No partial result is visible afterwards.

## Timing
- Start is sampled at the edge ending cycle n.
- Normal division:
  - CALC occupies cycles n+1 through n+32 and FIX occupies cycle n+33.
  - EndDivFlag is high for cycle n+34 only.
  - Busy is high from n+1 through n+34.
- Divide by zero: EndDivFlag and Busy are high in cycle n+1 only.
- A back-to-back Start is accepted no earlier than cycle n+35 (n+2 after a divide by zero). A Start in the DONE cycle is ignored.
- No combinational path from any input to any output.

## Structure
- Shared package mips_pkg gets:
  - the typedef div_state_t: IDLE, CALC, FIX, DONE;
  - the constant DIV_ITERS=32;
  - the constant DIV_ZERO_QUOT=32'hFFFFFFFF.
- One natural sub-module is div_step: a combinational single restoring iteration. Its inputs are rem, dividend MSB and divisor; its outputs are the next rem and the quotient bit. It is instantiated once in the CALC datapath.
- Sign handling (magnitudes and fix-up negation) stays inline in divide_unit.

## Test plan
- Unsigned 100 / 7 -> Lo=14, Hi=2, EndDivFlag exactly in cycle n+34, DivZero=0.
- Signed -7 / 2 (A=0xFFFFFFF9, B=2) -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. The same operands unsigned -> Lo=0x7FFFFFFC, Hi=1.
- A=0x12345678, B=0, with Signed=0 and again with Signed=1 -> in both runs, EndDivFlag in cycle n+1, DivZero=1, Hi=0x12345678, Lo=0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0. Signed 7 / -2 -> Lo=0xFFFFFFFD, Hi=1.
- Start re-pulsed at n+5 with different operands -> ignored; the first result is delivered at n+34 and Busy stays high throughout.
- Reset asserted at cycle n+10 -> the next cycle shows IDLE, with Hi, Lo, Busy, EndDivFlag and DivZero all 0. A subsequent 9 / 3 completes normally with Lo=3, Hi=0.
